// File: rtl/key_gpio_pkg.sv
// Shared register map and edge-select encodings for the key/switch input port.
package key_gpio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/key_gpio_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-count debouncer.
module key_gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (reset) stable <= 1'b0;
        else       stable <= s2;
      end
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt;

      // Counter only runs while s2 disagrees with stable, and wraps to 0 on acceptance.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable <= 1'b0;
          cnt    <= '0;
        end else if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/key_gpio_in.sv
// Avalon-MM input PIO: debounced inputs, sticky edge capture and masked level interrupt.
module key_gpio_in
  import key_gpio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_writedata;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      key_gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .din    (in_port[gi]),
        .stable (stable[gi])
      );
    end
  endgenerate

  assign wr_en            = chipselect & ~write_n;
  assign unused_writedata = &{1'b0, writedata};

  always_comb begin
    edge_det = stable ^ stable_d;
    if (EDGE_TYPE == EDGE_RISE)      edge_det = stable & ~stable_d;
    else if (EDGE_TYPE == EDGE_FALL) edge_det = ~stable & stable_d;
  end

  always_comb begin
    edge_clr = '0;
    if (wr_en && address == ADDR_EDGECAP) edge_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
      default:      rd_next = '0;
    endcase
  end

  // New edges are OR-ed in after the clear so a coincident edge is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d    <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
    end else begin
      stable_d    <= stable;
      edgecapture <= (edgecapture & ~edge_clr) | edge_det;
      readdata    <= rd_next;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_key_gpio_in.sv
// Directed bench for key_gpio_in with WIDTH=4, DEBOUNCE_CYCLES=8, falling-edge capture.
module tb_key_gpio_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  key_gpio_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .EDGE_TYPE(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();
    d = readdata;
    $display("read  addr=%0d data=%h irq=%b", a, d, irq);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [2:0]  addrs [4];
    addrs = '{3'd0, 3'd2, 3'd3, 3'd5};
    reset = 1'b1; in_port = 4'hF; address = 3'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    ticks(3);
    n_checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state readdata=%h irq=%b required 0/0", readdata, irq);
    end
    reset = 1'b0;
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      n_checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d readdata=%h irq=%b required 0/0", addrs[i], d, irq);
      end
    end
    ticks(20);
    rd(3'd0, d);
    n_checks++;
    if (d !== 32'hF) begin
      n_fail++;
      $display("FAIL idle_data readdata=%h required %h", d, 32'hF);
    end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_rise_ignored edgecapture=%h required 0", d);
    end
  endtask

  task automatic test_debounce_fall();
    logic [31:0] d;
    wr(3'd2, 32'h1);
    address = 3'd0;
    in_port[0] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) begin
        n_checks++;
        if (readdata !== 32'hF || irq !== 1'b0) begin
          n_fail++;
          $display("FAIL fall_edge10 readdata=%h irq=%b required F/0", readdata, irq);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (readdata !== 32'hE || irq !== 1'b1) begin
          n_fail++;
          $display("FAIL fall_edge11 readdata=%h irq=%b required E/1", readdata, irq);
        end
      end
    end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL fall_edgecap edgecapture=%h required 1", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    wr(3'd3, 32'hF);
    in_port[1] = 1'b0;
    ticks(7);
    in_port[1] = 1'b1;
    ticks(14);
    rd(3'd0, d);
    n_checks++;
    if (d !== 32'hE) begin
      n_fail++;
      $display("FAIL glitch_data readdata=%h required E", d);
    end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_edgecap edgecapture=%h irq=%b required 0/0", d, irq);
    end
  endtask

  task automatic test_w1c_mask();
    logic [31:0] d;
    in_port[0] = 1'b1;
    ticks(14);
    in_port[1:0] = 2'b00;
    ticks(14);
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++;
      $display("FAIL w1c_setup edgecapture=%h required 3", d);
    end
    wr(3'd2, 32'h2);
    wr(3'd3, 32'h1);
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_clear edgecapture=%h irq=%b required 2/1", d, irq);
    end
    wr(3'd2, 32'h1);
    rd(3'd2, d);
    n_checks++;
    if (d !== 32'h1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_irq irqmask=%h irq=%b required 1/0", d, irq);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    in_port[2] = 1'b0;
    ticks(10);
    address = 3'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h6) begin
      n_fail++;
      $display("FAIL set_wins edgecapture=%h required 6", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(3'd3, 32'hF);
    in_port[3] = 1'b0;
    ticks(14);
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h8) begin
      n_fail++;
      $display("FAIL rmid_setup edgecapture=%h required 8", d);
    end
    wr(3'd2, 32'hF);
    in_port[0] = 1'b1;
    ticks(7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_reset irq=%b readdata=%h required 0/0", irq, readdata);
    end
    rd(3'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_irqmask irqmask=%h required 0", d);
    end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_edgecap edgecapture=%h required 0", d);
    end
    ticks(15);
    rd(3'd0, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL rmid_data readdata=%h required 1", d);
    end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_no_edge edgecapture=%h irq=%b required 0/0", d, irq);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_fall();
    test_glitch();
    test_w1c_mask();
    test_set_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
